bus_arbiter_n: RTL



---
 rtl/bus_arbiter_n.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_n
// Brief    : N-requester bus arbiter with round-robin or fixed priority,
//            registered one-hot grant and bounded tenure while others wait.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter_n #(
  parameter  int NUM_REQ  = 4,
  parameter  int RR_MODE  = 1,
  parameter  int MAX_HOLD = 256,
  localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int HC_W     = $clog2(MAX_HOLD + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] in_reqcyc,
  input  logic [NUM_REQ-1:0] in_busy,
  output logic [NUM_REQ-1:0] out_grant,
  output logic               out_grant_valid,
  output logic [IDX_W-1:0]   out_grant_idx,
  output logic               out_timeout,
  output logic               out_bus_busy
);

  // The hold counter needs at least one bit even when forced release is off.
  localparam int CNT_W = (HC_W > 0) ? HC_W : 1;
  localparam int SUM_W = IDX_W + 1;

  localparam logic [CNT_W-1:0] c_max_hold = CNT_W'(MAX_HOLD);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_REQ - 1);
  localparam logic [SUM_W-1:0] c_num_req  = SUM_W'(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_HANDOFF = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] w_grant_nxt;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   w_owner_nxt;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic [CNT_W-1:0]   r_hold_cnt;
  logic [CNT_W-1:0]   w_hold_cnt_nxt;
  logic [CNT_W-1:0]   w_hold_inc;
  logic               r_timeout;
  logic               w_timeout_nxt;
  logic               r_bus_busy;

  logic [IDX_W-1:0]   w_base;
  logic [SUM_W-1:0]   w_cand;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_win_found;
  logic [IDX_W-1:0]   w_ptr_win;
  logic               w_own_req;
  logic               w_own_busy;
  logic               w_others;
  logic               w_hold_hit;

  // Fixed priority is a round-robin search that always starts at index 0.
  assign w_base = (RR_MODE != 0) ? r_ptr : '0;

  always_comb begin
    w_win_idx   = '0;
    w_win_found = 1'b0;
    w_cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = {1'b0, w_base} + SUM_W'(i);
      if (w_cand >= c_num_req) begin
        w_cand = w_cand - c_num_req;
      end
      if (!w_win_found && in_reqcyc[w_cand[IDX_W-1:0]]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand[IDX_W-1:0];
      end
    end
  end

  assign w_ptr_win  = (w_win_idx == c_last_idx) ? '0 : w_win_idx + 1'b1;
  assign w_own_req  = in_reqcyc[r_owner];
  assign w_own_busy = in_busy[r_owner];
  assign w_others   = |(in_reqcyc & ~r_grant);
  assign w_hold_inc = (r_hold_cnt == c_max_hold) ? r_hold_cnt : r_hold_cnt + 1'b1;

  // Compare the count including the current cycle, so an idle owner keeps the
  // bus for at most MAX_HOLD cycles when someone else is waiting.
  assign w_hold_hit = (MAX_HOLD > 0) && (w_hold_inc == c_max_hold);

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_owner_nxt    = r_owner;
    w_ptr_nxt      = r_ptr;
    w_hold_cnt_nxt = r_hold_cnt;
    w_timeout_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_win_found) begin
          w_state_nxt    = ST_GRANT;
          w_grant_nxt    = NUM_REQ'(1) << w_win_idx;
          w_owner_nxt    = w_win_idx;
          w_ptr_nxt      = w_ptr_win;
          w_hold_cnt_nxt = '0;
        end
      end
      ST_GRANT: begin
        if (!w_own_req && !w_own_busy) begin
          w_state_nxt = ST_HANDOFF;
          w_grant_nxt = '0;
          w_owner_nxt = '0;
        end else if (w_hold_hit && !w_own_busy && w_others) begin
          w_state_nxt   = ST_HANDOFF;
          w_grant_nxt   = '0;
          w_owner_nxt   = '0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_hold_cnt_nxt = w_hold_inc;
        end
      end
      ST_HANDOFF: begin
        w_state_nxt    = ST_IDLE;
        w_hold_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_grant_nxt    = '0;
        w_owner_nxt    = '0;
        w_hold_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
      r_bus_busy <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_owner    <= w_owner_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
      r_bus_busy <= |in_busy;
    end
  end

  assign out_grant       = r_grant;
  assign out_grant_valid = |r_grant;
  assign out_grant_idx   = r_owner;
  assign out_timeout     = r_timeout;
  assign out_bus_busy    = r_bus_busy;

endmodule
`default_nettype wire
